// File: rtl/pong_ctrl_pkg.sv
// Shared definitions for the pong game-sequencing controller:
// FSM state encoding, overlay select codes, counter widths and a BCD helper.
package pong_ctrl_pkg;

    localparam int unsigned SCORE_W = 8;
    localparam int unsigned BALL_W  = 2;
    localparam int unsigned TIMER_W = 8;

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [1:0] TXT_SCORE = 2'b00;
    localparam logic [1:0] TXT_RULE  = 2'b01;
    localparam logic [1:0] TXT_OVER  = 2'b10;

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = s[3:0];
        tens = s[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame-count wait timer used between balls and after game over.
// Ports:
//   clk, reset  - system clock, async active-high reset (count -> 0)
//   load        - reload count with WAIT_FRAMES (has priority over frame_tick)
//   frame_tick  - one-cycle pulse per frame; decrements a nonzero count
//   timer_up    - count has reached zero
module pong_frame_timer
    import pong_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_FRAMES = 120
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic frame_tick,
    output logic timer_up
);

    logic [TIMER_W-1:0] count;

    // Load wins over a coincident frame_tick; count parks at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= TIMER_W'(WAIT_FRAMES);
        end else if (frame_tick && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign timer_up = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-sequencing controller: serves balls, keeps the BCD score and
// remaining-ball count, and selects ball freeze / text overlay per mode.
// Ports:
//   clk, reset   - system clock, async active-high reset
//   frame_tick   - one-cycle pulse per frame (drives the wait timer)
//   btn[1:0]     - debounced paddle buttons; any bit set counts as pressed
//   hit, miss    - one-cycle ball events from the graphics generator
//   graph_still  - 1 = ball parked at centre
//   text_sel     - overlay select (score / rules / game over)
//   score[7:0]   - two BCD digits, [7:4] = tens
//   balls_left   - balls not yet served
module pong_game_ctrl
    import pong_ctrl_pkg::*;
#(
    parameter int unsigned BALLS       = 3,
    parameter int unsigned WAIT_FRAMES = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [1:0]         btn,
    input  logic               hit,
    input  logic               miss,
    output logic               graph_still,
    output logic [1:0]         text_sel,
    output logic [SCORE_W-1:0] score,
    output logic [BALL_W-1:0]  balls_left
);

    state_t             state;
    state_t             state_next;
    logic [SCORE_W-1:0] score_next;
    logic [BALL_W-1:0]  balls_next;
    logic               still_next;
    logic [1:0]         text_next;
    logic               load;
    logic               timer_up;
    logic               pressed;

    assign pressed = (btn != 2'b00);

    pong_frame_timer #(
        .WAIT_FRAMES(WAIT_FRAMES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .frame_tick(frame_tick),
        .timer_up  (timer_up)
    );

    // State, counters and mode outputs; mode outputs are registered from the
    // next state so they stay aligned with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= NEWGAME;
            score       <= '0;
            balls_left  <= BALL_W'(BALLS);
            graph_still <= 1'b1;
            text_sel    <= TXT_RULE;
        end else begin
            state       <= state_next;
            score       <= score_next;
            balls_left  <= balls_next;
            graph_still <= still_next;
            text_sel    <= text_next;
        end
    end

    // Next-state, score and ball-count logic.
    always_comb begin
        state_next = state;
        score_next = score;
        balls_next = balls_left;
        load       = 1'b0;
        case (state)
            NEWGAME: begin
                if (pressed) begin
                    state_next = PLAY;
                    balls_next = balls_left - BALL_W'(1);
                end
            end
            PLAY: begin
                if (hit) begin
                    score_next = bcd_inc(score);
                end
                if (miss) begin
                    load       = 1'b1;
                    state_next = (balls_left == '0) ? OVER : NEWBALL;
                end
            end
            NEWBALL: begin
                if (timer_up && pressed) begin
                    state_next = PLAY;
                    balls_next = balls_left - BALL_W'(1);
                end
            end
            OVER: begin
                if (timer_up) begin
                    state_next = NEWGAME;
                    score_next = '0;
                    balls_next = BALL_W'(BALLS);
                end
            end
            default: state_next = NEWGAME;
        endcase
    end

    // Mode decode of the upcoming state.
    always_comb begin
        still_next = 1'b1;
        text_next  = TXT_SCORE;
        case (state_next)
            NEWGAME: text_next  = TXT_RULE;
            PLAY:    still_next = 1'b0;
            NEWBALL: text_next  = TXT_SCORE;
            OVER:    text_next  = TXT_OVER;
            default: text_next  = TXT_RULE;
        endcase
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the pong display pipeline. It sits beside the VGA sync unit and the graphics/text generators in the pong top level. It consumes frame ticks, debounced buttons and hit/miss events from the graphics generator. It drives the mode controls (ball frozen or moving, which text overlay to show), the two-digit BCD score and the remaining-ball count.

## Interface
Parameters:
- BALLS, 3: balls per game; legal range 1..3, held in a 2-bit counter.
- WAIT_FRAMES, 120: frames to wait in NEWBALL and OVER (2 s at 60 Hz); legal range 1..255.

Ports:
- clk  in  1  system clock; the same clock drives VGA sync.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, asserted at pixel_x==0, pixel_y==481 and qualified by the pixel tick.
- btn  in  2  debounced paddle button levels; "pressed" means btn != 2'b00.
- hit  in  1  one-cycle pulse when the ball bounces off the paddle.
- miss  in  1  one-cycle pulse when the ball passes the paddle.
- graph_still  out  1  1 = the graphics generator parks the ball at centre and ignores movement.
- text_sel  out  2  overlay select: 00 = score only, 01 = rules screen, 10 = game-over screen.
- score  out  8  score as two BCD digits; [7:4] is the tens digit.
- balls_left  out  2  balls not yet served.

## Operation
- FSM states: NEWGAME, PLAY, NEWBALL, OVER.
- NEWGAME:
  - Outputs: graph_still=1, text_sel=01.
  - On pressed: go to PLAY, and decrement balls_left.
- PLAY:
  - Outputs: graph_still=0, text_sel=00.
  - On hit: score increments in BCD. 99 wraps to 00.
  - On miss with balls_left==0: go to OVER and load the timer.
  - On miss with balls_left!=0: go to NEWBALL and load the timer.
- NEWBALL:
  - Outputs: graph_still=1, text_sel=00.
  - When timer_up and pressed: go to PLAY, and decrement balls_left.
  - A button held through the wait is accepted on the first cycle timer_up is true.
- OVER:
  - Outputs: graph_still=1, text_sel=10.
  - When timer_up: go to NEWGAME. On that same transition, clear score to 8'h00 and load balls_left=BALLS.
- Timer:
  - Count width is 8 bits.
  - A load sets the count to WAIT_FRAMES.
  - The count decrements on each frame_tick while nonzero.
  - timer_up = (count==0).
- Events outside their states:
  - hit and miss are ignored outside PLAY.
  - Buttons are ignored in PLAY and OVER.
- Simultaneous hit and miss in PLAY: the score increments and the miss transition is also taken.
- frame_tick coinciding with a timer load: the load wins.

## Timing
- Reset values:
  - state NEWGAME, graph_still=1, text_sel=01.
  - score=8'h00, balls_left=BALLS, timer count=0.
- Outputs are Moore, decoded from the registered state, counters and score. There are no combinational paths from inputs to outputs.
- Input sampled at edge N (pressed, hit or miss): the resulting state, score and balls_left change is visible after edge N.
- Timer length:
  - The timer is loaded on the edge that enters NEWBALL or OVER.
  - timer_up first goes true after the WAIT_FRAMES-th frame_tick.
  - Wait duration is WAIT_FRAMES frames, or WAIT_FRAMES-1 frames plus a partial frame.
- Reset asserted mid-operation, including mid-wait: all outputs return to reset values immediately (asynchronously).

## Structure
- Shared package pong_ctrl_pkg holds:
  - state encoding: NEWGAME=2'b00, PLAY=2'b01, NEWBALL=2'b10, OVER=2'b11;
  - text_sel codes: TXT_SCORE, TXT_RULE, TXT_OVER.
- One sub-module, pong_frame_timer. Ports: clk, reset, load, frame_tick, timer_up. Parameter: WAIT_FRAMES.
- The BCD score counter and the ball counter are inline in pong_game_ctrl.

## Test plan
- Reset, then btn=01 for one cycle -> state PLAY next cycle, graph_still=0, balls_left=2, text_sel=00.
- In PLAY, 12 hit pulses -> score=8'h12. From score 8'h99, one hit -> 8'h00.
- In PLAY with balls_left=2, a miss -> NEWBALL, graph_still=1.
  - btn held from the miss onward, WAIT_FRAMES=4 -> PLAY exactly on the cycle after the 4th frame_tick; balls_left=1.
  - btn pressed before the 4th frame_tick and released -> no transition.
- Serve all three balls, then miss with balls_left=0 -> OVER, text_sel=10. After WAIT_FRAMES frame_ticks -> NEWGAME, score=8'h00, balls_left=3.
- hit and miss in the same cycle with score 8'h05 -> score=8'h06 and state NEWBALL. hit pulses in NEWGAME/NEWBALL/OVER -> score unchanged.
- Reset asserted mid-NEWBALL wait, independent of clk edge -> state NEWGAME, score 00, balls_left=3, timer 0. After release, btn press -> PLAY.
